// File: rtl/dsp_acc_seq_pkg.sv
// Shared types and constants for the DSP accumulate sequencer.
package dsp_acc_seq_pkg;

   localparam int A_W = 20;
   localparam int B_W = 18;
   localparam int Z_W = 38;

   localparam logic [2:0] FEEDBACK_ACC = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/dsp_acc_seq_if.sv
// Operand stream, DSP pin and result bundle between the sequencer and its neighbours.
// slave = sequencer side, master = source/DSP/consumer side.
interface dsp_acc_seq_if;
   import dsp_acc_seq_pkg::*;

   logic             s_valid_i;
   logic             s_ready_o;
   logic [A_W-1:0]   s_a_i;
   logic [B_W-1:0]   s_b_i;
   logic [A_W-1:0]   a_o;
   logic [B_W-1:0]   b_o;
   logic             load_acc_o;
   logic [2:0]       feedback_o;
   logic [Z_W-1:0]   z_i;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [Z_W-1:0]   res_data_o;

   modport slave (
      input  s_valid_i, s_a_i, s_b_i, z_i, res_ready_i,
      output s_ready_o, a_o, b_o, load_acc_o, feedback_o, res_valid_o, res_data_o
   );

   modport master (
      output s_valid_i, s_a_i, s_b_i, z_i, res_ready_i,
      input  s_ready_o, a_o, b_o, load_acc_o, feedback_o, res_valid_o, res_data_o
   );

endinterface

// File: rtl/dsp_acc_seq_cnt.sv
// Loadable down-counter with zero flag; stops at zero.
module dsp_acc_seq_cnt #(
   parameter int W = 8
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // load has priority over decrement; decrement saturates at zero
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (dec && (cnt_q != '0))
         cnt_q <= cnt_q - W'(1);
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/dsp_acc_sequencer.sv
// Sequencer in front of the 20x18 DSP MAC: streams one job of operand pairs into
// the DSP and captures the finished accumulator value.
// Optional feature macro: DSP_ACC_SEQ_ABORT_EN (adds abort_i).
//
// state    | meaning
// ST_IDLE  | waiting for start_i, DSP pins parked at zero
// ST_RUN   | accepting operand beats, bubbles add zero products
// ST_DRAIN | waiting DSP_LATENCY+1 edges for the last product to reach z_i
// ST_HOLD  | result presented until res_ready_i
module dsp_acc_sequencer
   import dsp_acc_seq_pkg::*;
#(
   parameter int LEN_W       = 8,
   parameter int DSP_LATENCY = 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
`ifdef DSP_ACC_SEQ_ABORT_EN
   input  logic             abort_i,
`endif
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   dsp_acc_seq_if.slave     bus
);

   localparam int DR_W = (DSP_LATENCY < 1) ? 1 : $clog2(DSP_LATENCY + 1);

   seq_state_e     state_q, state_n;
   logic           seen_q, seen_n;
   logic [A_W-1:0] a_q, a_n;
   logic [B_W-1:0] b_q, b_n;
   logic           ld_q, ld_n;
   logic           rv_q, rv_n;
   logic [Z_W-1:0] rd_q, rd_n;
   logic           accept, abort_w;
   logic           beat_load, beat_zero;
   logic           drain_load, drain_dec, drain_zero;

`ifdef DSP_ACC_SEQ_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   assign accept = (state_q == ST_RUN) && bus.s_valid_i;

   // beat counter holds beats remaining after the current one
   dsp_acc_seq_cnt #(.W(LEN_W)) u_beat_cnt (
      .clk_sys  (clock_i),
      .rst_b    (reset_i),
      .load     (beat_load),
      .load_val (len_i - LEN_W'(1)),
      .dec      (accept),
      .zero     (beat_zero)
   );

   dsp_acc_seq_cnt #(.W(DR_W)) u_drain_cnt (
      .clk_sys  (clock_i),
      .rst_b    (reset_i),
      .load     (drain_load),
      .load_val (DR_W'(DSP_LATENCY)),
      .dec      (drain_dec),
      .zero     (drain_zero)
   );

   // state and registered DSP/result outputs
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ST_IDLE;
         seen_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ld_q    <= 1'b0;
         rv_q    <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_n;
         seen_q  <= seen_n;
         a_q     <= a_n;
         b_q     <= b_n;
         ld_q    <= ld_n;
         rv_q    <= rv_n;
         rd_q    <= rd_n;
      end
   end

   // next state and next register values; load_acc follows "any beat seen yet"
   always_comb begin
      state_n    = state_q;
      seen_n     = seen_q;
      a_n        = '0;
      b_n        = '0;
      ld_n       = 1'b0;
      rv_n       = rv_q;
      rd_n       = rd_q;
      beat_load  = 1'b0;
      drain_load = 1'b0;
      drain_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            seen_n = 1'b0;
            if (start_i) begin
               if (len_i != '0) begin
                  beat_load = 1'b1;
                  state_n   = ST_RUN;
               end else begin
                  rd_n    = '0;
                  rv_n    = 1'b1;
                  state_n = ST_HOLD;
               end
            end
         end
         ST_RUN: begin
            ld_n = seen_q;
            if (accept) begin
               a_n    = bus.s_a_i;
               b_n    = bus.s_b_i;
               seen_n = 1'b1;
               if (beat_zero) begin
                  drain_load = 1'b1;
                  state_n    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            drain_dec = 1'b1;
            if (drain_zero) begin
               rd_n    = bus.z_i;
               rv_n    = 1'b1;
               state_n = ST_HOLD;
            end else begin
               ld_n = 1'b1;
            end
         end
         ST_HOLD: begin
            if (bus.res_ready_i) begin
               rv_n    = 1'b0;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (abort_w && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
         state_n    = ST_IDLE;
         a_n        = '0;
         b_n        = '0;
         ld_n       = 1'b0;
         rv_n       = rv_q;
         rd_n       = rd_q;
         drain_load = 1'b0;
      end
   end

   assign bus.s_ready_o   = (state_q == ST_RUN);
   assign bus.a_o         = a_q;
   assign bus.b_o         = b_q;
   assign bus.load_acc_o  = ld_q;
   assign bus.feedback_o  = FEEDBACK_ACC;
   assign bus.res_valid_o = rv_q;
   assign bus.res_data_o  = rd_q;
   assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dsp_acc_sequencer.sv
// Bench for dsp_acc_sequencer with a behavioural latency-1 DSP MAC; expected
// results are dot products of the driven operand lists.
module tb_dsp_acc_sequencer;
   import dsp_acc_seq_pkg::*;

   localparam int LEN_W = 8;
   localparam int LAT   = 1;

   logic             clock_i = 1'b0;
   logic             reset_i = 1'b0;
   logic             start_i = 1'b0;
   logic [LEN_W-1:0] len_i   = '0;
   logic             busy_o;
`ifdef DSP_ACC_SEQ_ABORT_EN
   logic             abort_i = 1'b0;
`endif

   dsp_acc_seq_if bus();

   dsp_acc_sequencer #(.LEN_W(LEN_W), .DSP_LATENCY(LAT)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
`ifdef DSP_ACC_SEQ_ABORT_EN
      .abort_i (abort_i),
`endif
      .start_i (start_i),
      .len_i   (len_i),
      .busy_o  (busy_o),
      .bus     (bus)
   );

   always #5 clock_i = ~clock_i;

   // DSP MAC: acc restarts from the product when load_acc is 0, else adds it
   logic signed [37:0] dsp_acc, dsp_prod;
   assign dsp_prod = 38'($signed(bus.a_o)) * 38'($signed(bus.b_o));
   always @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) dsp_acc <= '0;
      else          dsp_acc <= bus.load_acc_o ? dsp_acc + dsp_prod : dsp_prod;
   end
   assign bus.z_i = dsp_acc;

   int n_tot = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [19:0] qa[$];
   logic [17:0] qb[$];
   int          qg[$];

   function automatic logic [37:0] ref_dot();
      longint s = 0;
      foreach (qa[i]) s += longint'($signed(qa[i])) * longint'($signed(qb[i]));
      return s[37:0];
   endfunction

   task automatic push_beat(input int a, input int b, input int gap);
      qa.push_back(20'(a));
      qb.push_back(18'(b));
      qg.push_back(gap);
   endtask

   task automatic clear_job();
      qa.delete(); qb.delete(); qg.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ready"}, 64'(bus.s_ready_o), 0);
      check_val({tag, "_a"},     64'(bus.a_o), 0);
      check_val({tag, "_b"},     64'(bus.b_o), 0);
      check_val({tag, "_ld"},    64'(bus.load_acc_o), 0);
      check_val({tag, "_fb"},    64'(bus.feedback_o), 0);
      check_val({tag, "_rv"},    64'(bus.res_valid_o), 0);
      check_val({tag, "_rd"},    64'(bus.res_data_o), 0);
      check_val({tag, "_busy"},  64'(busy_o), 0);
   endtask

   // runs the queued job; rst_after >= 0 pulses reset right after that beat
   task automatic run_job(input int hold_cyc, input int rst_after);
      int          n;
      int          waitc;
      logic [37:0] exp_res;
      n       = qa.size();
      exp_res = (n == 0) ? 38'd0 : ref_dot();
      check_val("idle_busy", 64'(busy_o), 0);
      start_i = 1'b1;
      len_i   = LEN_W'(n);
      @(posedge clock_i); #1;
      start_i = 1'b0;
      if (n == 0) begin
         check_val("zl_valid", 64'(bus.res_valid_o), 1);
         check_val("zl_data",  64'(bus.res_data_o), 0);
         check_val("zl_a",     64'(bus.a_o), 0);
         check_val("zl_b",     64'(bus.b_o), 0);
      end else begin
         check_val("run_ready", 64'(bus.s_ready_o), 1);
         for (int i = 0; i < n; i++) begin
            for (int g = 0; g < qg[i]; g++) begin
               bus.s_valid_i = 1'b0;
               bus.s_a_i     = 20'($urandom);
               bus.s_b_i     = 18'($urandom);
               @(posedge clock_i); #1;
               check_val("bub_a",  64'(bus.a_o), 0);
               check_val("bub_b",  64'(bus.b_o), 0);
               check_val("bub_ld", 64'(bus.load_acc_o), 64'(i > 0));
            end
            bus.s_valid_i = 1'b1;
            bus.s_a_i     = qa[i];
            bus.s_b_i     = qb[i];
            @(posedge clock_i); #1;
            bus.s_valid_i = 1'b0;
            check_val("beat_a",  64'(bus.a_o), 64'(qa[i]));
            check_val("beat_b",  64'(bus.b_o), 64'(qb[i]));
            check_val("beat_ld", 64'(bus.load_acc_o), 64'(i > 0));
            if (i == rst_after) begin
               reset_i = 1'b0;
               #1;
               check_all_zero("rst");
               #1;
               reset_i = 1'b1;
               repeat (4) begin
                  @(posedge clock_i); #1;
                  check_val("post_rst_rv",   64'(bus.res_valid_o), 0);
                  check_val("post_rst_busy", 64'(busy_o), 0);
               end
               return;
            end
         end
         check_val("drain_ready", 64'(bus.s_ready_o), 0);
         waitc = 0;
         while (!bus.res_valid_o && waitc < 20) begin
            @(posedge clock_i); #1;
            waitc++;
         end
         check_val("res_lat",  64'(waitc), 64'(LAT + 1));
         check_val("res_data", 64'(bus.res_data_o), 64'(exp_res));
      end
      start_i = 1'b1;
      len_i   = LEN_W'(3);
      for (int h = 0; h < hold_cyc; h++) begin
         bus.res_ready_i = 1'b0;
         @(posedge clock_i); #1;
         check_val("hold_valid", 64'(bus.res_valid_o), 1);
         check_val("hold_data",  64'(bus.res_data_o), 64'(exp_res));
         check_val("hold_ready", 64'(bus.s_ready_o), 0);
      end
      start_i         = 1'b0;
      bus.res_ready_i = 1'b1;
      @(posedge clock_i); #1;
      bus.res_ready_i = 1'b0;
      check_val("hs_valid", 64'(bus.res_valid_o), 0);
      check_val("hs_busy",  64'(busy_o), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      bus.s_valid_i   = 1'b0;
      bus.s_a_i       = '0;
      bus.s_b_i       = '0;
      bus.res_ready_i = 1'b0;
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clock_i);
      #1 reset_i = 1'b1;
      @(posedge clock_i); #1;

      // directed dot product, no bubbles
      clear_job();
      push_beat(1, 1, 0); push_beat(2, 3, 0); push_beat(-1, 5, 0); push_beat(7, -2, 0);
      run_job(0, -1);

      // same job with three bubbles between beats 2 and 3
      qg[2] = 3;
      run_job(1, -1);

      // zero-length job
      clear_job();
      run_job(2, -1);

      // result held against back-pressure
      clear_job();
      push_beat(-5, 9, 0); push_beat(100, -100, 1);
      run_job(10, -1);

      // reset after beat 2 of 5, then a clean job
      clear_job();
      for (int i = 0; i < 5; i++) push_beat(i + 4, 2 * i + 1, 0);
      run_job(0, 1);
      clear_job();
      push_beat(3, 3, 0); push_beat(1, 1, 0);
      run_job(0, -1);

      // single beat and full-length job with extreme operands
      clear_job();
      push_beat(-524288, -131072, 2);
      run_job(0, -1);
      clear_job();
      for (int i = 0; i < 255; i++) push_beat(-524288, -131072, 0);
      run_job(0, -1);

`ifdef DSP_ACC_SEQ_ABORT_EN
      // abort while draining discards the job
      start_i = 1'b1; len_i = LEN_W'(1);
      @(posedge clock_i); #1;
      start_i = 1'b0;
      bus.s_valid_i = 1'b1; bus.s_a_i = 20'd7; bus.s_b_i = 18'd7;
      @(posedge clock_i); #1;
      bus.s_valid_i = 1'b0;
      abort_i = 1'b1;
      @(posedge clock_i); #1;
      abort_i = 1'b0;
      check_val("abort_busy", 64'(busy_o), 0);
      check_val("abort_a",    64'(bus.a_o), 0);
      check_val("abort_ld",   64'(bus.load_acc_o), 0);
      repeat (4) begin
         @(posedge clock_i); #1;
         check_val("abort_rv", 64'(bus.res_valid_o), 0);
      end
`endif

      // randomized jobs
      for (int j = 0; j < 12; j++) begin
         clear_job();
         len = $urandom_range(0, 12);
         for (int i = 0; i < len; i++)
            push_beat(int'($urandom), int'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         run_job($urandom_range(0, 3), -1);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
